// File: rtl/student_tlul_arbiter.sv
// N-host to 1-device TL-UL arbiter: round-robin grant, one outstanding transaction,
// and the grant is held from the A-channel grant until the D-channel handshake.

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module student_tlul_arbiter
  import tlul_pkg::*;
#(
  parameter int NUM_HOSTS = 2,
  parameter int GW        = $clog2(NUM_HOSTS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  tl_h2d_t [NUM_HOSTS-1:0] tl_host_i,
  output tl_d2h_t [NUM_HOSTS-1:0] tl_host_o,
  input  tl_d2h_t                 tl_device_o,
  output tl_h2d_t                 tl_device_i,
  output logic    [GW-1:0]        grant_o,
  output logic                    busy_o,
  output logic    [31:0]          txn_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] w_grant_nxt;
  logic [31:0]   r_txn_cnt;

  logic          w_req_found;
  logic [GW-1:0] w_req_pick;
  logic          w_d_hs;
  tl_h2d_t       w_gnt_req;

  assign w_gnt_req = tl_host_i[r_grant];
  assign w_d_hs    = (r_state == RESP) && tl_device_o.d_valid && w_gnt_req.d_ready;

  // Round-robin scan: the host just after the last grant has the highest priority.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path through it can infer a latch.
    w_req_found = 1'b0;
    w_req_pick  = r_grant;
    for (int k = 1; k <= NUM_HOSTS; k++) begin
      if (!w_req_found && tl_host_i[(int'(r_grant) + k) % NUM_HOSTS].a_valid) begin
        w_req_found = 1'b1;
        w_req_pick  = GW'((int'(r_grant) + k) % NUM_HOSTS);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    unique case (r_state)
      IDLE: begin
        if (w_req_found) begin
          w_state_nxt = ADDR;
          w_grant_nxt = w_req_pick;
        end
      end
      ADDR: begin
        // A granted host that withdraws its request gives the slot back without a count.
        if (!w_gnt_req.a_valid) begin
          w_state_nxt = IDLE;
        end else if (tl_device_o.a_ready) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_d_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tl_device_i = '0;
    tl_host_o   = '0;
    unique case (r_state)
      ADDR: begin
        tl_device_i                 = w_gnt_req;
        tl_device_i.d_ready         = 1'b0;
        tl_host_o[r_grant].a_ready  = tl_device_o.a_ready;
      end
      RESP: begin
        tl_device_i.d_ready         = w_gnt_req.d_ready;
        tl_host_o[r_grant]          = tl_device_o;
        tl_host_o[r_grant].a_ready  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_grant   <= GW'(NUM_HOSTS - 1);
      r_txn_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      if (w_d_hs && (r_txn_cnt != '1)) begin
        r_txn_cnt <= r_txn_cnt + 32'd1;
      end
    end
  end

  assign grant_o   = r_grant;
  assign busy_o    = (r_state != IDLE);
  assign txn_cnt_o = r_txn_cnt;

endmodule

// File: tb/tb_student_tlul_arbiter.sv
// Self-checking bench for student_tlul_arbiter with three hosts: directed sequences,
// a table of round-robin vectors, and randomized traffic against a transaction-level model.

module tb_student_tlul_arbiter;
  import tlul_pkg::*;

  localparam int NH = 3;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  tl_h2d_t [NH-1:0]     tl_host;
  tl_d2h_t [NH-1:0]     tl_host_o;
  tl_d2h_t              dev;
  tl_h2d_t              tl_device_i;
  logic    [1:0]        grant_o;
  logic                 busy_o;
  logic    [31:0]       txn_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  student_tlul_arbiter #(.NUM_HOSTS(NH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tl_host_i   (tl_host),
    .tl_host_o   (tl_host_o),
    .tl_device_o (dev),
    .tl_device_i (tl_device_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .txn_cnt_o   (txn_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] host_addr(input int h);
    return 32'h0010_0004 + 32'(h << 8);
  endfunction

  function automatic tl_h2d_t mk_req(input int h, input logic [31:0] addr);
    tl_h2d_t r;
    r           = '0;
    r.a_valid   = 1'b1;
    r.a_opcode  = 3'h4;
    r.a_size    = 2'd2;
    r.a_source  = 8'(h);
    r.a_address = addr;
    r.a_mask    = 4'hF;
    r.d_ready   = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] resp_fn(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Spec rule: first requester after the last grant, wrapping modulo the host count.
  function automatic int rr_pick(input int last, input logic [NH-1:0] m);
    for (int k = 1; k <= NH; k++) begin
      if (m[(last + k) % NH]) return (last + k) % NH;
    end
    return -1;
  endfunction

  // Invariants checked every cycle: at most one host is talked to, and nothing moves while idle.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      int act;
      logic any_h;
      act   = 0;
      any_h = 1'b0;
      for (int h = 0; h < NH; h++) begin
        if (tl_host_o[h].a_ready || tl_host_o[h].d_valid) begin
          act++;
          any_h = 1'b1;
        end
      end
      check("mon_single_host", 32'(act <= 1), 32'd1);
      if (!busy_o) begin
        check("mon_idle_quiet", 32'({any_h, tl_device_i.a_valid, tl_device_i.d_ready}), 32'd0);
      end
    end
  end

  task automatic do_reset();
    rst_ni  = 1'b0;
    tl_host = '0;
    dev     = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // One full transaction; called and returning one time unit after a rising edge.
  task automatic run_txn(input logic [NH-1:0] mask, input int a_wait, input int d_wait,
                         input logic [31:0] rdata, output int hs, output int g,
                         output logic [31:0] got, output int lat);
    logic [31:0] snap_addr;
    logic [NH-1:0] others;
    int n;
    hs  = -1;
    g   = -1;
    got = '0;
    lat = -1;
    for (int h = 0; h < NH; h++) begin
      if (mask[h]) tl_host[h] = mk_req(h, host_addr(h));
      else tl_host[h].a_valid = 1'b0;
      tl_host[h].d_ready = 1'b1;
    end
    dev = '0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!tl_device_i.a_valid && n < 20);
    if (!tl_device_i.a_valid) begin
      check("txn_grant_timeout", 32'd0, 32'd1);
      tl_host = '0;
      return;
    end
    lat       = n - 1;
    hs        = int'(tl_device_i.a_source);
    g         = int'(grant_o);
    snap_addr = tl_device_i.a_address;
    if (hs >= NH) begin
      check("txn_bad_source", 32'(hs), 32'(g));
      tl_host = '0;
      return;
    end
    others = '0;
    for (int h = 0; h < NH; h++) if (h != hs) others[h] = tl_host_o[h].a_ready;
    check("txn_ungranted_a_ready", 32'(others), 32'd0);
    for (int k = 0; k < a_wait; k++) begin
      @(posedge clk_i);
      #1;
      dev.d_valid = 1'b1;
      dev.d_data  = 32'hBAD0_0000;
      @(negedge clk_i);
      check("addr_wait_grant", 32'(grant_o), 32'(hs));
      check("addr_wait_a_stable", tl_device_i.a_address, snap_addr);
      check("addr_wait_no_fwd", 32'({tl_host_o[hs].d_valid, tl_host_o[hs].a_ready, tl_device_i.d_ready}), 32'd0);
    end
    @(posedge clk_i);
    #1;
    dev.d_valid = 1'b0;
    dev.a_ready = 1'b1;
    @(negedge clk_i);
    check("txn_host_a_ready", 32'(tl_host_o[hs].a_ready), 32'd1);
    @(posedge clk_i);
    #1;
    dev.a_ready         = 1'b0;
    tl_host[hs].a_valid = 1'b0;
    dev.d_valid         = 1'b1;
    dev.d_opcode        = 3'h1;
    dev.d_source        = 8'(hs);
    dev.d_data          = rdata;
    tl_host[hs].d_ready = (d_wait == 0);
    for (int k = 0; k < d_wait; k++) begin
      @(negedge clk_i);
      check("resp_wait_d_fwd", {tl_host_o[hs].d_valid, tl_host_o[hs].d_data[30:0]}, {1'b1, rdata[30:0]});
      check("resp_wait_ready", 32'({tl_device_i.d_ready, tl_host_o[hs].a_ready, tl_device_i.a_valid}), 32'd0);
      check("resp_wait_grant", 32'(grant_o), 32'(hs));
      @(posedge clk_i);
      #1;
    end
    tl_host[hs].d_ready = 1'b1;
    @(negedge clk_i);
    got = tl_host_o[hs].d_data;
    check("txn_dev_d_ready", 32'(tl_device_i.d_ready), 32'd1);
    @(posedge clk_i);
    #1;
    dev = '0;
  endtask

  task automatic random_phase(input int ncyc);
    logic [31:0]   addr [NH];
    bit            outst [NH];
    logic [NH-1:0] snap, cur;
    int last_g, rsp_delay, rsp_src, issued, done, cyc, acc_h, exp_h;
    bit rsp_pend, any_out;
    logic [31:0] rsp_addr;
    last_g    = NH - 1;
    snap      = '0;
    rsp_pend  = 1'b0;
    rsp_delay = 0;
    rsp_src   = 0;
    rsp_addr  = '0;
    issued    = 0;
    done      = 0;
    cyc       = 0;
    any_out   = 1'b0;
    for (int h = 0; h < NH; h++) begin
      outst[h] = 1'b0;
      addr[h]  = '0;
    end
    while ((cyc < ncyc || any_out) && cyc < ncyc + 500) begin
      @(negedge clk_i);
      acc_h = -1;
      for (int h = 0; h < NH; h++) cur[h] = tl_host[h].a_valid;
      if (!busy_o) snap = cur;
      if (tl_device_i.a_valid && dev.a_ready) begin
        exp_h = rr_pick(last_g, snap);
        acc_h = int'(tl_device_i.a_source) % NH;
        check("rand_a_host", 32'(tl_device_i.a_source), 32'(exp_h));
        check("rand_a_addr", tl_device_i.a_address, (exp_h >= 0) ? addr[exp_h] : 32'hFFFF_FFFF);
        last_g    = exp_h;
        issued++;
        rsp_pend  = 1'b1;
        rsp_src   = acc_h;
        rsp_addr  = tl_device_i.a_address;
        rsp_delay = int'($urandom_range(0, 3));
      end
      for (int h = 0; h < NH; h++) begin
        if (tl_host_o[h].d_valid && tl_host[h].d_ready) begin
          check("rand_d_host", 32'(h), 32'(rsp_src));
          check("rand_d_data", tl_host_o[h].d_data, resp_fn(addr[h]));
          outst[h] = 1'b0;
          rsp_pend = 1'b0;
          done++;
        end
      end
      @(posedge clk_i);
      #1;
      any_out = 1'b0;
      for (int h = 0; h < NH; h++) begin
        if (h == acc_h) tl_host[h].a_valid = 1'b0;
        if (!outst[h] && cyc < ncyc && $urandom_range(0, 2) == 0) begin
          addr[h]    = $urandom() & 32'hFFFF_FFFC;
          tl_host[h] = mk_req(h, addr[h]);
          outst[h]   = 1'b1;
        end
        tl_host[h].d_ready = ($urandom_range(0, 3) != 0);
        any_out = any_out | outst[h];
      end
      dev.a_ready = 1'($urandom_range(0, 1));
      if (rsp_pend && rsp_delay == 0) begin
        dev.d_valid  = 1'b1;
        dev.d_opcode = 3'h1;
        dev.d_source = 8'(rsp_src);
        dev.d_data   = resp_fn(rsp_addr);
      end else begin
        if (rsp_pend) rsp_delay--;
        dev.d_valid = 1'b0;
      end
      cyc++;
    end
    check("rand_drained", 32'(any_out), 32'd0);
    check("rand_txn_cnt", txn_cnt_o, 32'(issued));
    check("rand_done_cnt", 32'(done), 32'(issued));
  endtask

  typedef struct {
    logic [NH-1:0] mask;
    int            exp_host;
    logic [31:0]   rdata;
  } vec_t;

  initial begin
    vec_t tbl [14];
    int hs, g, lat, n;
    logic [31:0] got;

    tbl[0]  = '{mask: 3'b111, exp_host: 0, rdata: 32'hA000_0000};
    tbl[1]  = '{mask: 3'b111, exp_host: 1, rdata: 32'hA000_0001};
    tbl[2]  = '{mask: 3'b111, exp_host: 2, rdata: 32'hA000_0002};
    tbl[3]  = '{mask: 3'b111, exp_host: 0, rdata: 32'hA000_0003};
    tbl[4]  = '{mask: 3'b111, exp_host: 1, rdata: 32'hA000_0004};
    tbl[5]  = '{mask: 3'b111, exp_host: 2, rdata: 32'hA000_0005};
    tbl[6]  = '{mask: 3'b101, exp_host: 0, rdata: 32'hA000_0006};
    tbl[7]  = '{mask: 3'b101, exp_host: 2, rdata: 32'hA000_0007};
    tbl[8]  = '{mask: 3'b011, exp_host: 0, rdata: 32'hA000_0008};
    tbl[9]  = '{mask: 3'b010, exp_host: 1, rdata: 32'hA000_0009};
    tbl[10] = '{mask: 3'b100, exp_host: 2, rdata: 32'hA000_000A};
    tbl[11] = '{mask: 3'b110, exp_host: 1, rdata: 32'hA000_000B};
    tbl[12] = '{mask: 3'b001, exp_host: 0, rdata: 32'hA000_000C};
    tbl[13] = '{mask: 3'b110, exp_host: 1, rdata: 32'hA000_000D};

    tl_host = '0;
    dev     = '0;
    rst_ni  = 1'b0;

    @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'(NH - 1));
    check("rst_txn_cnt", txn_cnt_o, 32'd0);
    check("rst_dev_zero", 32'(tl_device_i != '0), 32'd0);
    check("rst_host_zero", 32'(tl_host_o != '0), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Single Get from host 0 with a zero-wait device.
    run_txn(3'b001, 0, 0, 32'hDEAD_BEEF, hs, g, got, lat);
    check("get_host", 32'(hs), 32'd0);
    check("get_latency", 32'(lat), 32'd1);
    check("get_data", got, 32'hDEAD_BEEF);
    @(negedge clk_i);
    check("get_txn_cnt", txn_cnt_o, 32'd1);
    check("get_busy_low", 32'(busy_o), 32'd0);

    // Spurious device response while idle is not forwarded.
    @(posedge clk_i);
    #1;
    dev.d_valid = 1'b1;
    dev.d_data  = 32'h0BAD_0BAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n = 0;
      for (int h = 0; h < NH; h++) n += int'(tl_host_o[h].d_valid);
      check("idle_spurious_d", 32'({n[7:0], 7'd0, tl_device_i.d_ready}), 32'd0);
    end
    @(posedge clk_i);
    #1 dev = '0;

    // Stalled device and stalled host: host 1 keeps the grant while all hosts request.
    run_txn(3'b111, 5, 4, 32'hCAFE_0001, hs, g, got, lat);
    tl_host = '0;
    check("hold_host", 32'(hs), 32'd1);
    check("hold_grant", 32'(g), 32'd1);
    check("hold_data", got, 32'hCAFE_0001);
    @(negedge clk_i);
    check("hold_txn_once", txn_cnt_o, 32'd2);
    @(posedge clk_i);
    #1;

    // Simultaneous requests from hosts 0 and 1 after reset.
    do_reset();
    run_txn(3'b011, 0, 0, 32'h1234_0000, hs, g, got, lat);
    check("pair_first", 32'(g), 32'd0);
    run_txn(3'b010, 0, 0, 32'h1234_0001, hs, g, got, lat);
    check("pair_second", 32'(g), 32'd1);
    check("pair_second_data", got, 32'h1234_0001);
    tl_host = '0;

    // Round-robin vectors from a fresh reset.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i].mask, 0, 0, tbl[i].rdata, hs, g, got, lat);
      check($sformatf("tbl%0d_host", i), 32'(hs), 32'(tbl[i].exp_host));
      check($sformatf("tbl%0d_grant", i), 32'(g), 32'(tbl[i].exp_host));
      check($sformatf("tbl%0d_data", i), got, tbl[i].rdata);
      check($sformatf("tbl%0d_cnt", i), txn_cnt_o, 32'(i + 1));
    end
    tl_host = '0;

    // Asynchronous reset while a response is on the device D channel.
    tl_host[0] = mk_req(0, host_addr(0));
    dev.a_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!tl_device_i.a_valid && n < 20);
    check("rst_mid_reach_addr", 32'(tl_device_i.a_valid), 32'd1);
    @(posedge clk_i);
    #1;
    dev.a_ready        = 1'b0;
    tl_host[0].a_valid = 1'b0;
    tl_host[0].d_ready = 1'b0;
    dev.d_valid        = 1'b1;
    dev.d_data         = 32'h1111_2222;
    @(negedge clk_i);
    check("rst_mid_in_resp", 32'(tl_host_o[0].d_valid), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_grant", 32'(grant_o), 32'(NH - 1));
    check("rst_mid_cnt", txn_cnt_o, 32'd0);
    check("rst_mid_dev_zero", 32'(tl_device_i != '0), 32'd0);
    check("rst_mid_host_zero", 32'(tl_host_o != '0), 32'd0);
    @(posedge clk_i);
    #1;
    dev     = '0;
    tl_host = '0;
    rst_ni  = 1'b1;
    run_txn(3'b001, 0, 0, 32'h600D_0000, hs, g, got, lat);
    check("rst_mid_next_host", 32'(hs), 32'd0);
    check("rst_mid_next_data", got, 32'h600D_0000);
    check("rst_mid_next_cnt", txn_cnt_o, 32'd1);

    // Granted host withdraws its request before the A handshake.
    tl_host[2]  = mk_req(2, host_addr(2));
    dev.a_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!tl_device_i.a_valid && n < 20);
    check("drop_grant", 32'(grant_o), 32'd2);
    @(posedge clk_i);
    #1 tl_host[2].a_valid = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("drop_busy", 32'(busy_o), 32'd0);
    check("drop_grant_kept", 32'(grant_o), 32'd2);
    check("drop_no_count", txn_cnt_o, 32'd1);
    check("drop_dev_a_valid", 32'(tl_device_i.a_valid), 32'd0);
    @(posedge clk_i);
    #1;

    do_reset();
    random_phase(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
